// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the registered ALU slice.
//   MODE_W        - width of the operation select bus
//   DEFAULT_WIDTH - default operand width
//   alu_op_e      - 4-bit opcode encoding (ADD..PASS)
package alu_pkg;

  localparam int unsigned MODE_W        = 4;
  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [MODE_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_NOT  = 4'd6,
    OP_SHL  = 4'd7,
    OP_SHR  = 4'd8,
    OP_SRA  = 4'd9,
    OP_ROL  = 4'd10,
    OP_ROR  = 4'd11,
    OP_EQ   = 4'd12,
    OP_LTU  = 4'd13,
    OP_LTS  = 4'd14,
    OP_PASS = 4'd15
  } alu_op_e;

endpackage

// File: rtl/alu_if.sv
// alu_if: operand/result bundle for alu_unit.
//   A, B  - WIDTH-bit operands
//   mode  - operation select
//   Y     - 2*WIDTH-bit registered result
// master drives operands and reads Y; slave is the ALU side.
interface alu_if
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic [MODE_W-1:0]  mode;
  logic [2*WIDTH-1:0] Y;

  modport master (output A, output B, output mode, input Y);
  modport slave  (input A, input B, input mode, output Y);

endinterface

// File: rtl/alu_shifter.sv
// alu_shifter: combinational shift/rotate unit.
//   A      - WIDTH-bit operand
//   amount - shift/rotate distance, log2(WIDTH) bits
//   opcode - one of SHL/SHR/SRA/ROL/ROR; any other opcode yields 0
//   result - WIDTH-bit shifted value
module alu_shifter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0]         A,
  input  logic [$clog2(WIDTH)-1:0] amount,
  input  alu_op_e                  opcode,
  output logic [WIDTH-1:0]         result
);

  logic [2*WIDTH-1:0] rol_wide;
  logic [2*WIDTH-1:0] ror_wide;

  // Rotates shift a doubled copy of A so wrapped bits fall into the kept half.
  always_comb begin
    rol_wide = {A, A} << amount;
    ror_wide = {A, A} >> amount;
  end

  always_comb begin
    result = '0;
    case (opcode)
      OP_SHL:  result = A << amount;
      OP_SHR:  result = A >> amount;
      OP_SRA:  result = $unsigned($signed(A) >>> amount);
      OP_ROL:  result = rol_wide[2*WIDTH-1:WIDTH];
      OP_ROR:  result = ror_wide[WIDTH-1:0];
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_unit.sv
// alu_unit: registered arithmetic/logic unit, one-cycle latency.
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset, clears Y
//   A, B  - WIDTH-bit operands (B[log2(WIDTH)-1:0] is the shift amount)
//   mode  - 4-bit opcode (alu_pkg::alu_op_e)
//   Y     - 2*WIDTH-bit registered result, unused upper bits 0
// Build option: define ALU_MUL_EN to build the unsigned multiplier;
// without it opcode MUL returns 0.
module alu_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [MODE_W-1:0]    mode,
  output logic [2*WIDTH-1:0]   Y
);

  localparam int unsigned SHW = $clog2(WIDTH);

  alu_op_e            op;
  logic [WIDTH-1:0]   shift_res;
  logic [2*WIDTH-1:0] res;

  // All 16 encodings are enumerated, so the cast never yields an unnamed value.
  assign op = alu_op_e'(mode);

  alu_shifter #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .A      (A),
    .amount (B[SHW-1:0]),
    .opcode (op),
    .result (shift_res)
  );

  always_comb begin
    res = '0;
    case (op)
      // Bit WIDTH is carry-out for ADD and borrow for SUB.
      OP_ADD:  res[WIDTH:0]   = {1'b0, A} + {1'b0, B};
      OP_SUB:  res[WIDTH:0]   = {1'b0, A} - {1'b0, B};
`ifdef ALU_MUL_EN
      OP_MUL:  res            = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
`else
      OP_MUL:  res            = '0;
`endif
      OP_AND:  res[WIDTH-1:0] = A & B;
      OP_OR:   res[WIDTH-1:0] = A | B;
      OP_XOR:  res[WIDTH-1:0] = A ^ B;
      OP_NOT:  res[WIDTH-1:0] = ~A;
      OP_SHL,
      OP_SHR,
      OP_SRA,
      OP_ROL,
      OP_ROR:  res[WIDTH-1:0] = shift_res;
      OP_EQ:   res[0]         = (A == B);
      OP_LTU:  res[0]         = (A < B);
      OP_LTS:  res[0]         = ($signed(A) < $signed(B));
      OP_PASS: res[WIDTH-1:0] = A;
      default: res            = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) Y <= '0;
    else        Y <= res;
  end

endmodule

// File: tb/tb_alu_unit.sv
module tb_alu_unit;
  import alu_pkg::*;

  localparam int unsigned W = 8;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  alu_if #(.WIDTH(W)) bus ();

  alu_unit #(
    .WIDTH (W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (bus.A),
    .B     (bus.B),
    .mode  (bus.mode),
    .Y     (bus.Y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference model, written bit-serially for shifts/rotates.
  function automatic logic [15:0] golden(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] m);
    logic [15:0] r;
    logic [7:0]  t;
    int unsigned s;
    r = '0;
    t = a;
    s = b[2:0];
    case (m)
      4'd0:  r = {8'h00, a} + {8'h00, b};
      4'd1:  begin r[7:0] = a - b; r[8] = (a < b); end
`ifdef ALU_MUL_EN
      4'd2:  r = {8'h00, a} * {8'h00, b};
`else
      4'd2:  r = '0;
`endif
      4'd3:  r[7:0] = a & b;
      4'd4:  r[7:0] = a | b;
      4'd5:  r[7:0] = a ^ b;
      4'd6:  r[7:0] = ~a;
      4'd7:  begin for (int i = 0; i < s; i++) t = {t[6:0], 1'b0};  r[7:0] = t; end
      4'd8:  begin for (int i = 0; i < s; i++) t = {1'b0, t[7:1]};  r[7:0] = t; end
      4'd9:  begin for (int i = 0; i < s; i++) t = {t[7], t[7:1]};  r[7:0] = t; end
      4'd10: begin for (int i = 0; i < s; i++) t = {t[6:0], t[7]};  r[7:0] = t; end
      4'd11: begin for (int i = 0; i < s; i++) t = {t[0], t[7:1]};  r[7:0] = t; end
      4'd12: r[0] = (a == b);
      4'd13: r[0] = (a < b);
      4'd14: r[0] = (a[7] != b[7]) ? a[7] : (a[6:0] < b[6:0]);
      default: r[7:0] = a;
    endcase
    return r;
  endfunction

  // Drive one operation between edges and return after it has been captured.
  task automatic apply(input logic [7:0] a, input logic [7:0] b, input logic [3:0] m);
    @(negedge clk);
    bus.A    = a;
    bus.B    = b;
    bus.mode = m;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      #(i == 0 ? 2 : 6);
      vectors++;
      if (bus.Y !== 16'h0000) begin
        miscompares++;
        $display("FAIL reset_hold[%0d]: Y=%h expected 0000", i, bus.Y);
      end
    end
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (bus.Y !== 16'h01FE) begin
      miscompares++;
      $display("FAIL reset_first_edge: Y=%h expected 01fe", bus.Y);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.Y !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_async: Y=%h expected 0000", bus.Y);
    end
    #2 rst_n = 1'b1;
  endtask

  task automatic test_arith;
    logic [7:0]  ta [3] = '{8'd200, 8'd5, 8'd7};
    logic [7:0]  tb [3] = '{8'd100, 8'd7, 8'd5};
    logic [3:0]  tm [3] = '{4'd0, 4'd1, 4'd1};
    logic [15:0] te [3] = '{16'h012C, 16'h01FE, 16'h0002};
    for (int i = 0; i < 3; i++) begin
      apply(ta[i], tb[i], tm[i]);
      vectors++;
      if (bus.Y !== te[i]) begin
        miscompares++;
        $display("FAIL arith[%0d]: Y=%h expected %h", i, bus.Y, te[i]);
      end
    end
  endtask

  task automatic test_mul;
    logic [15:0] exp;
`ifdef ALU_MUL_EN
    exp = 16'hFE01;
`else
    exp = 16'h0000;
`endif
    apply(8'hFF, 8'hFF, 4'd2);
    vectors++;
    if (bus.Y !== exp) begin
      miscompares++;
      $display("FAIL mul_255x255: Y=%h expected %h", bus.Y, exp);
    end
  endtask

  task automatic test_logic_shift;
    logic [7:0]  ta [5] = '{8'hF0, 8'h0F, 8'h80, 8'h81, 8'h81};
    logic [7:0]  tb [5] = '{8'h3C, 8'hAA, 8'h03, 8'h01, 8'h01};
    logic [3:0]  tm [5] = '{4'd3, 4'd6, 4'd9, 4'd10, 4'd7};
    logic [15:0] te [5] = '{16'h0030, 16'h00F0, 16'h00F0, 16'h0003, 16'h0002};
    for (int i = 0; i < 5; i++) begin
      apply(ta[i], tb[i], tm[i]);
      vectors++;
      if (bus.Y !== te[i]) begin
        miscompares++;
        $display("FAIL logic_shift[%0d]: Y=%h expected %h", i, bus.Y, te[i]);
      end
    end
    // Amount 0 on every shift/rotate leaves A unchanged.
    for (int m = 7; m <= 11; m++) begin
      apply(8'hA5, 8'h08, 4'(m));
      vectors++;
      if (bus.Y !== 16'h00A5) begin
        miscompares++;
        $display("FAIL shift_zero[mode %0d]: Y=%h expected 00a5", m, bus.Y);
      end
    end
  endtask

  task automatic test_compare;
    logic [7:0]  ta [3] = '{8'h80, 8'h80, 8'h5A};
    logic [7:0]  tb [3] = '{8'h01, 8'h01, 8'h5A};
    logic [3:0]  tm [3] = '{4'd14, 4'd13, 4'd12};
    logic [15:0] te [3] = '{16'h0001, 16'h0000, 16'h0001};
    for (int i = 0; i < 3; i++) begin
      apply(ta[i], tb[i], tm[i]);
      vectors++;
      if (bus.Y !== te[i]) begin
        miscompares++;
        $display("FAIL compare[%0d]: Y=%h expected %h", i, bus.Y, te[i]);
      end
    end
  endtask

  // New inputs every cycle; Y at each falling edge must reflect the inputs
  // present at the preceding rising edge.
  task automatic test_back_to_back;
    logic [15:0] exp_prev;
    logic [7:0]  a;
    logic [7:0]  b;
    exp_prev = '0;
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      if (i > 0) begin
        vectors++;
        if (bus.Y !== exp_prev) begin
          miscompares++;
          $display("FAIL back_to_back[mode %0d]: Y=%h expected %h", i - 1, bus.Y, exp_prev);
        end
      end
      if (i < 16) begin
        a = 8'($urandom);
        b = 8'($urandom);
        bus.A    = a;
        bus.B    = b;
        bus.mode = 4'(i);
        exp_prev = golden(a, b, 4'(i));
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    bus.A       = 8'hFF;
    bus.B       = 8'hFF;
    bus.mode    = 4'd0;
    test_reset();
    test_arith();
    test_mul();
    test_logic_shift();
    test_compare();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_unit.md
# alu_unit

Registered arithmetic/logic unit. Two WIDTH-bit operands are combined according to a 4-bit operation code, and the result is captured into an output register on every rising clock edge. It is a standalone datapath leaf driven straight from the operand bus (A, B, mode), with no handshake. The registered result Y is consumed one cycle later.

## Interface
- WIDTH, default 8: operand width in bits; must be ≥ 2 and a power of two.
- clk  input  1: single clock; all state updates on the rising edge.
- rst_n  input  1: reset, asynchronous and active-low. Asserting it clears all state immediately.
- A  input  WIDTH: operand A, unsigned unless the operation says signed.
- B  input  WIDTH: operand B; for shifts/rotates only B[log2(WIDTH)-1:0] is the amount.
- mode  input  4: operation select.
- Y  output  2*WIDTH: registered result.

## Operation
- The result is computed combinationally from A, B and mode, then registered into Y. Unused upper bits of Y are always 0.
- Opcodes:
  - 0 ADD: Y[WIDTH:0] = A+B; bit WIDTH is the carry-out.
  - 1 SUB: Y[WIDTH-1:0] = A−B mod 2^WIDTH; Y[WIDTH] = borrow (1 iff A<B unsigned).
  - 2 MUL: Y = A×B unsigned, full 2*WIDTH product.
  - 3 AND: Y[WIDTH-1:0] = A&B.
  - 4 OR: Y[WIDTH-1:0] = A|B.
  - 5 XOR: Y[WIDTH-1:0] = A^B.
  - 6 NOT: Y[WIDTH-1:0] = ~A; B is ignored.
  - 7 SHL: logical left shift of A, zero fill, result truncated to WIDTH.
  - 8 SHR: logical right shift of A.
  - 9 SRA: arithmetic right shift of A (sign fill).
  - 10 ROL: rotate A left.
  - 11 ROR: rotate A right.
  - 12 EQ: Y = 1 iff A==B, else 0.
  - 13 LTU: Y = 1 iff A<B unsigned.
  - 14 LTS: Y = 1 iff A<B, two's-complement signed.
  - 15 PASS: Y[WIDTH-1:0] = A.
- Shift/rotate by amount 0 returns A unchanged.
- No X propagation: every opcode and every operand value gives a defined result.

## Timing
- Latency is exactly 1 cycle: inputs sampled at edge N appear on Y after edge N. Throughput is one operation per cycle.
- Reset value: Y = 0. Reset clears Y asynchronously the moment rst_n goes low, independent of clk, including mid-stream.
- While rst_n is low, Y holds 0 and inputs are ignored.
- On the first rising edge after rst_n deasserts, Y captures the result of the inputs present at that edge.
- A mode change between edges affects only the next capture. There are no multi-cycle operations and no stall.

## Configuration
- Macro ALU_MUL_EN.
- Defined: opcode 2 is the full unsigned multiplier as specified.
- Undefined: no multiplier hardware is built; opcode 2 produces Y = 0. All other opcodes are unaffected.

## Structure
- A shared package alu_pkg holds:
  - the 4-bit opcode enum (ADD…PASS, values as above);
  - the width of mode (4);
  - the default WIDTH constant.
- One sub-module is natural: alu_shifter (parameter WIDTH; inputs A, amount, opcode; one WIDTH-bit result) covering SHL/SHR/SRA/ROL/ROR.
- Top level contains the arithmetic, logic, compare, output mux and output register.

## Test plan
All cases use WIDTH=8.
1. Reset: hold rst_n=0 for 15 time units with A=0xFF, B=0xFF, mode=ADD -> Y=0x0000 throughout. Drop rst_n mid-cycle after a valid result -> Y=0 immediately, without waiting for an edge.
2. Arithmetic:
   - ADD 200+100 -> Y=0x012C one cycle later.
   - SUB 5−7 -> Y=0x01FE.
   - SUB 7−5 -> Y=0x0002.
3. Multiply: MUL 255×255 -> Y=0xFE01 with ALU_MUL_EN defined; Y=0x0000 without it.
4. Logic/shift:
   - AND 0xF0,0x3C -> 0x0030.
   - NOT 0x0F -> 0x00F0.
   - SRA 0x80 by 3 -> 0x00F0.
   - ROL 0x81 by 1 -> 0x0003.
   - SHL 0x81 by 1 -> 0x0002.
5. Compare:
   - LTS A=0x80, B=0x01 -> Y=1.
   - LTU same operands -> Y=0.
   - EQ 0x5A,0x5A -> Y=1.
6. Back-to-back: change mode every cycle through all 16 opcodes with random A/B -> each Y matches the golden model for the previous cycle's inputs, with no bubbles.
